// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//
// Parametrised single-clock FIFO. Words are held in a dual-port RAM indexed by
// read and write pointers; the occupancy count and every status flag are
// registered and computed from the next-state count. This means all of them
// move on the same clock edge as the count, and no input reaches a flag
// through combinational logic alone. Read data is registered, so it appears
// one cycle after a read is accepted.
//
// Ports
//   clk           in   rising-edge clock (only clock domain)
//   rst_n         in   asynchronous active-low reset, released on clk
//   wr_en         in   write request
//   wr_data       in   word to write (DATA_WIDTH)
//   rd_en         in   read request
//   rd_data       out  registered read word (DATA_WIDTH)
//   rd_valid      out  rd_data holds a word popped on the previous edge
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  occupancy 0..DEPTH (ADDR_WIDTH+1 bits)
//   overflow      out  one-cycle pulse after a rejected write
//   underflow     out  one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_af_check
        $error("param_sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_ae_check
        $error("param_sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  overflow_q, underflow_q;
    logic                  rd_acc, wr_acc;

    // A read frees a slot on the same edge, so a full FIFO may still
    // accept a write when a read is accepted alongside it.
    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the cleared pointers make old words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // The read samples the RAM before this edge's write lands, which gives
    // read-before-write behaviour when both hit one address while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
            rd_valid_q  <= rd_acc;
            full_q      <= (count_d == DEPTH_LVL);
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= AF_LVL);
            ae_q        <= (count_d <= AE_LVL);
            overflow_q  <= wr_en & ~wr_acc;
            underflow_q <= rd_en & ~rd_acc;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Self-checking bench for param_sync_fifo with the default parameters
// (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1). The stimulus tasks keep a
// reference queue. Each accepted read pushes its expected word into expQ. A
// separate monitor pops expQ whenever the DUT raises rd_valid and compares the
// popped word with rd_data.
// ---------------------------------------------------------------------------
module tb_param_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] modelQ[$];
    logic [7:0] expQ[$];
    bit         expOvf, expUnf, expValid;

    param_sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line if it disagrees.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares every status output against the reference model.
    task automatic checkOutput();
        int n;
        n = modelQ.size();
        checkVal("count",        32'(count),        32'(n));
        checkVal("full",         32'(full),         32'(n == 8));
        checkVal("empty",        32'(empty),        32'(n == 0));
        checkVal("almost_full",  32'(almost_full),  32'(n >= 6));
        checkVal("almost_empty", 32'(almost_empty), 32'(n <= 1));
        checkVal("overflow",     32'(overflow),     32'(expOvf));
        checkVal("underflow",    32'(underflow),    32'(expUnf));
        checkVal("rd_valid",     32'(rd_valid),     32'(expValid));
    endtask

    // Drives one cycle of requests and advances the reference model.
    // Inputs change 1 ns after a rising edge. The model applies the read
    // first, so a full FIFO returns its oldest word.
    task automatic applyStimulus(input bit wr, input logic [7:0] d, input bit rd);
        bit rdAcc, wrAcc;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        rdAcc = rd && (modelQ.size() != 0);
        wrAcc = wr && ((modelQ.size() != 8) || rdAcc);
        if (rdAcc) expQ.push_back(modelQ.pop_front());
        if (wrAcc) modelQ.push_back(d);
        expOvf   = wr && !wrAcc;
        expUnf   = rd && !rdAcc;
        expValid = rdAcc;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkOutput();
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_empty"},    32'(empty),        32'd1);
        checkVal({tag, "_full"},     32'(full),         32'd0);
        checkVal({tag, "_count"},    32'(count),        32'd0);
        checkVal({tag, "_rd_valid"}, 32'(rd_valid),     32'd0);
        checkVal({tag, "_rd_data"},  32'(rd_data),      32'h00);
        checkVal({tag, "_af"},       32'(almost_full),  32'd0);
        checkVal({tag, "_ae"},       32'(almost_empty), 32'd1);
        checkVal({tag, "_ovf"},      32'(overflow),     32'd0);
        checkVal({tag, "_unf"},      32'(underflow),    32'd0);
    endtask

    // Scoreboard monitor: on the falling edge, each valid read word must
    // match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL rd_spurious: got %0h expected no word", rd_data);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("[TB] FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        expOvf  = 1'b0;
        expUnf  = 1'b0;
        expValid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkReset("init");

        // Fill and drain: almost_full rises on the 6th write, full on the 8th.
        $display("[TB] fill/drain");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Overflow: a write alone while full is dropped.
        $display("[TB] overflow");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Underflow: a read while empty is dropped, but the concurrent write lands.
        $display("[TB] underflow");
        applyStimulus(1'b1, 8'h55, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Simultaneous read and write while full.
        $display("[TB] simultaneous at full");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Interleaved push/pop over 40 cycles; both pointers wrap more than twice.
        $display("[TB] wrap");
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % 4) != 3, 8'h80 + 8'(i), (i % 3) != 0);
        end
        while (modelQ.size() != 0) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset mid-stream, asserted between clock edges.
        $display("[TB] async reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        modelQ.delete();
        expQ.delete();
        expOvf   = 1'b0;
        expUnf   = 1'b0;
        expValid = 1'b0;
        checkReset("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkReset("post_rst");
        applyStimulus(1'b1, 8'h66, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        checkVal("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stops a run that fails to reach the end of the stimulus sequence.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
